osd_ctrl: RTL and testbench

Command sequencer and configuration controller for the OSD overlay window. It takes a framed byte stream from the host link and a front-panel toggle button. It drives the overlay enable into the OSD mixer and writes text into the 32x32-character OSD buffer that the mixer's x/y coordinates index. Enable changes are deferred to the vsync rising edge so the overlay never appears or disappears mid-frame.

---
 rtl/osd_ctrl_if.sv | 22 ++
 rtl/osd_ctrl.sv | 140 ++++++++++++++
 tb/tb_osd_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/osd_ctrl_if.sv
// rtl/osd_ctrl_if.sv - host byte link and character buffer write bus for osd_ctrl
// master drives the host side; slave is the controller.
interface osd_ctrl_if #(
  parameter int C_addr_bits = 10
) ();
  logic                   i_frame;
  logic                   i_valid;
  logic [7:0]             i_data;
  logic                   o_wr_en;
  logic [C_addr_bits-1:0] o_wr_addr;
  logic [7:0]             o_wr_data;

  modport master (
    output i_frame, i_valid, i_data,
    input  o_wr_en, o_wr_addr, o_wr_data
  );

  modport slave (
    input  i_frame, i_valid, i_data,
    output o_wr_en, o_wr_addr, o_wr_data
  );
endinterface

// File: rtl/osd_ctrl.sv
// rtl/osd_ctrl.sv - OSD command sequencer: host byte frames to buffer writes, vsync-deferred enable
// Enable changes from host or button are held pending and applied on the vsync rising edge.
module osd_ctrl #(
  parameter int C_addr_bits  = 10,
  parameter bit C_en_default = 1'b0
) (
  input  logic        clk_pixel,
  input  logic        reset,
  osd_ctrl_if.slave   host,
  input  logic        i_btn,
  input  logic        i_vsync,
  output logic        o_osd_en,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EN_ARG,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
    S_SKIP
  } state_t;

  localparam logic [C_addr_bits-1:0] C_addr_one = C_addr_bits'(1);

  state_t                 state;
  state_t                 state_nx;
  logic                   r_frame_prev;
  logic                   r_btn_prev;
  logic                   r_vsync_prev;
  logic                   r_armed;
  logic                   pend_valid;
  logic                   pending_en;
  logic [C_addr_bits-1:0] addr;

  logic accept;
  logic frame_rise;
  logic cmd_take;
  logic btn_rise;
  logic vs_rise;
  logic cmd_en;
  logic new_valid;
  logic new_val;
  logic eff_val;

  assign accept     = host.i_valid & host.i_frame;
  assign frame_rise = host.i_frame & ~r_frame_prev;
  // r_armed covers the gap between the frame rising edge and its first byte
  assign cmd_take   = accept & (state == S_IDLE) & (r_armed | frame_rise);
  assign btn_rise   = i_btn & ~r_btn_prev;
  assign vs_rise    = i_vsync & ~r_vsync_prev;
  assign cmd_en     = accept & (state == S_EN_ARG);

  always_comb begin
    new_valid = cmd_en | btn_rise;
    new_val   = cmd_en ? host.i_data[0] : ~(pend_valid ? pending_en : o_osd_en);
    eff_val   = new_valid ? new_val : pending_en;
  end

  always_comb begin
    state_nx = state;
    if (!host.i_frame) begin
      state_nx = S_IDLE;
    end else if (accept) begin
      case (state)
        S_IDLE: begin
          if (cmd_take) begin
            case (host.i_data)
              8'h01:   state_nx = S_EN_ARG;
              8'h02:   state_nx = S_ADDR_HI;
              default: state_nx = S_SKIP;
            endcase
          end
        end
        S_EN_ARG:  state_nx = S_SKIP;
        S_ADDR_HI: state_nx = S_ADDR_LO;
        S_ADDR_LO: state_nx = S_DATA;
        S_DATA:    state_nx = S_DATA;
        S_SKIP:    state_nx = S_SKIP;
        default:   state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      o_busy         <= 1'b0;
      r_frame_prev   <= 1'b1;
      r_armed        <= 1'b0;
      addr           <= '0;
      host.o_wr_en   <= 1'b0;
      host.o_wr_addr <= '0;
      host.o_wr_data <= '0;
    end else begin
      state        <= state_nx;
      o_busy       <= (state_nx != S_IDLE);
      r_frame_prev <= host.i_frame;
      r_armed      <= host.i_frame & (r_armed | frame_rise) & ~cmd_take;
      host.o_wr_en <= 1'b0;
      if (accept) begin
        case (state)
          S_ADDR_HI: addr[C_addr_bits-1:8] <= host.i_data[C_addr_bits-9:0];
          S_ADDR_LO: addr[7:0] <= host.i_data;
          S_DATA: begin
            host.o_wr_en   <= 1'b1;
            host.o_wr_addr <= addr;
            host.o_wr_data <= host.i_data;
            addr           <= addr + C_addr_one;
          end
          default: ;
        endcase
      end
    end
  end

  // A new event coinciding with the vsync edge is applied directly rather than queued
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      o_osd_en     <= C_en_default;
      pending_en   <= C_en_default;
      pend_valid   <= 1'b0;
      r_btn_prev   <= 1'b0;
      r_vsync_prev <= 1'b0;
    end else begin
      r_btn_prev   <= i_btn;
      r_vsync_prev <= i_vsync;
      if (vs_rise && (new_valid || pend_valid)) begin
        o_osd_en   <= eff_val;
        pending_en <= eff_val;
        pend_valid <= 1'b0;
      end else if (new_valid) begin
        pending_en <= new_val;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_osd_ctrl.sv
// tb/tb_osd_ctrl.sv - self-checking bench for osd_ctrl: directed and random host frames
// Expected writes and enable state come from a frame-level model of the command rules.
module tb_osd_ctrl;

  logic clk_pixel = 1'b0;
  logic reset;
  logic i_btn;
  logic i_vsync;
  logic o_osd_en;
  logic o_busy;

  always #5 clk_pixel = ~clk_pixel;

  osd_ctrl_if #(.C_addr_bits(10)) bus ();

  osd_ctrl #(.C_addr_bits(10), .C_en_default(1'b0)) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .host      (bus.slave),
    .i_btn     (i_btn),
    .i_vsync   (i_vsync),
    .o_osd_en  (o_osd_en),
    .o_busy    (o_busy)
  );

  int errors = 0;
  int checks = 0;

  bit         m_en;
  bit         m_pend;
  bit         m_pending;
  logic [9:0] m_last_addr;
  logic [7:0] m_last_data;
  logic [7:0] fq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en        = 1'b0;
    m_pend      = 1'b0;
    m_pending   = 1'b0;
    m_last_addr = '0;
    m_last_data = '0;
  endtask

  // Sends fq as one frame; checks every write one clock after its byte
  task automatic send_frame(input bit gaps, input bit btn_with_arg);
    int         n;
    bit         is_wr;
    logic [9:0] a;
    n     = fq.size();
    is_wr = (n > 0) && (fq[0] == 8'h02);
    a     = '0;
    @(negedge clk_pixel);
    bus.i_frame = 1'b1;
    bus.i_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.i_valid = 1'b0;
        bus.i_data  = 8'($urandom);
        @(negedge clk_pixel);
        check("gap_wr_en", bus.o_wr_en, 0);
      end
      bus.i_valid = 1'b1;
      bus.i_data  = fq[i];
      if (btn_with_arg && i == 1) i_btn = 1'b1;
      @(negedge clk_pixel);
      bus.i_valid = 1'b0;
      if (i == 0) check("busy_after_cmd", o_busy, 1);
      if (i == 1 && fq[0] == 8'h01) begin
        m_pending = fq[1][0];
        m_pend    = 1'b1;
      end
      if (i == 2 && is_wr) a = {fq[1][1:0], fq[2]};
      if (is_wr && i >= 3) begin
        check("wr_en", bus.o_wr_en, 1);
        check("wr_addr", bus.o_wr_addr, a);
        check("wr_data", bus.o_wr_data, fq[i]);
        m_last_addr = a;
        m_last_data = fq[i];
        a = a + 10'd1;
      end else begin
        check("no_wr_en", bus.o_wr_en, 0);
      end
    end
    bus.i_frame = 1'b0;
    i_btn       = 1'b0;
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    check("busy_idle", o_busy, 0);
    check("hold_addr", bus.o_wr_addr, m_last_addr);
    check("hold_data", bus.o_wr_data, m_last_data);
    check("en_deferred", o_osd_en, m_en);
  endtask

  task automatic press_btn();
    @(negedge clk_pixel);
    i_btn     = 1'b1;
    m_pending = ~(m_pend ? m_pending : m_en);
    m_pend    = 1'b1;
    @(negedge clk_pixel);
    i_btn = 1'b0;
    check("en_after_btn", o_osd_en, m_en);
  endtask

  task automatic vsync_pulse();
    @(negedge clk_pixel);
    i_vsync = 1'b1;
    @(negedge clk_pixel);
    if (m_pend) begin
      m_en   = m_pending;
      m_pend = 1'b0;
    end
    check("en_vsync", o_osd_en, m_en);
    @(negedge clk_pixel);
    i_vsync = 1'b0;
    @(negedge clk_pixel);
    check("en_stable", o_osd_en, m_en);
  endtask

  initial begin
    reset       = 1'b1;
    bus.i_frame = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    i_btn       = 1'b0;
    i_vsync     = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_pixel);
    check("rst_osd_en", o_osd_en, 0);
    check("rst_wr_en", bus.o_wr_en, 0);
    check("rst_wr_addr", bus.o_wr_addr, 0);
    check("rst_wr_data", bus.o_wr_data, 0);
    check("rst_busy", o_busy, 0);
    reset = 1'b0;

    // Bytes with the frame low are ignored
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_pixel);
      bus.i_valid = 1'b1;
      bus.i_data  = (i == 0) ? 8'h02 : 8'h41;
    end
    @(negedge clk_pixel);
    bus.i_valid = 1'b0;
    check("noframe_busy", o_busy, 0);
    check("noframe_wr", bus.o_wr_en, 0);

    fq = '{8'h02, 8'h00, 8'h10, 8'h41, 8'h42, 8'h43};
    send_frame(1'b0, 1'b0);
    fq = '{8'h02, 8'h03, 8'hFF, 8'h55, 8'h66};
    send_frame(1'b0, 1'b0);

    fq = '{8'h01, 8'h01};
    send_frame(1'b0, 1'b0);
    vsync_pulse();
    vsync_pulse();

    // Button then host command in the same frame, then collision
    fq = '{8'h01, 8'h00};
    send_frame(1'b0, 1'b0);
    vsync_pulse();
    fq = '{8'h01, 8'h00};
    send_frame(1'b0, 1'b1);
    vsync_pulse();
    press_btn();
    vsync_pulse();

    // Button edge on the vsync edge is applied at once
    @(negedge clk_pixel);
    i_btn   = 1'b1;
    i_vsync = 1'b1;
    m_en    = ~(m_pend ? m_pending : m_en);
    m_pend  = 1'b0;
    @(negedge clk_pixel);
    check("en_btn_on_vsync", o_osd_en, m_en);
    i_btn   = 1'b0;
    i_vsync = 1'b0;
    vsync_pulse();

    fq = '{8'h7E, 8'h02, 8'h00, 8'h00, 8'h41};
    send_frame(1'b0, 1'b0);
    fq = '{8'h02, 8'h03};
    send_frame(1'b0, 1'b0);
    fq = '{8'h02, 8'h00, 8'h05, 8'h99};
    send_frame(1'b0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      int kind;
      int len;
      kind = $urandom_range(0, 3);
      fq.delete();
      if (kind == 0) begin
        fq.push_back(8'h01);
        if ($urandom_range(0, 3) != 0) fq.push_back(8'($urandom));
      end else if (kind == 3) begin
        len = $urandom_range(0, 4);
        for (int k = 0; k < len; k++) fq.push_back(8'($urandom));
      end else begin
        fq.push_back(8'h02);
        len = $urandom_range(0, 8);
        for (int k = 0; k < len; k++) fq.push_back(8'($urandom));
      end
      send_frame(1'b1, 1'b0);
      if ($urandom_range(0, 3) == 0) press_btn();
      if ($urandom_range(0, 2) == 0) vsync_pulse();
    end

    // Make the enable 1 so reset has something to clear
    if (!(m_pend ? m_pending : m_en)) press_btn();
    vsync_pulse();
    check("en_before_rst", o_osd_en, 1);

    @(negedge clk_pixel);
    bus.i_frame = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = (i == 0) ? 8'h02 : 8'h20 + 8'(i);
      @(negedge clk_pixel);
    end
    #2 reset = 1'b1;
    #1;
    check("midrst_osd_en", o_osd_en, 0);
    check("midrst_wr_en", bus.o_wr_en, 0);
    check("midrst_wr_addr", bus.o_wr_addr, 0);
    check("midrst_wr_data", bus.o_wr_data, 0);
    check("midrst_busy", o_busy, 0);
    model_reset();
    @(negedge clk_pixel);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = (i == 0) ? 8'h02 : 8'h30 + 8'(i);
      @(negedge clk_pixel);
      check("postrst_wr_en", bus.o_wr_en, 0);
      check("postrst_busy", o_busy, 0);
    end
    bus.i_valid = 1'b0;
    bus.i_frame = 1'b0;
    fq = '{8'h02, 8'h01, 8'h23, 8'h77, 8'h78};
    send_frame(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
